pb_debouncer: RTL and testbench
===============================

// Module: pb_debouncer
// PURPOSE
//   Debounces one mechanical push-button input for the Program-Counter board logic.
//   Synchronises the asynchronous button level into the clock domain.
//   Outputs a clean level (PB_state) only after the input has been stable for STABLE_CYCLES clocks.
//   Also emits single-cycle press/release strobes that drive PC step/load control.
// PARAMETERS
//   STABLE_CYCLES  100  consecutive clocks the synchronised input must differ from PB_state
//                       before PB_state flips (2 us at 50 MHz); must be >= 2
//   CNT_W          16   stability counter width; must satisfy 2**CNT_W > STABLE_CYCLES
// PORTS
//   clock     input   1  system clock; all logic is rising-edge
//   reset     input   1  synchronous, active-high reset
//   PB        input   1  raw button level, asynchronous, active-high (1 = pressed)
//   PB_state  output  1  debounced button level, registered
//   PB_down   output  1  one-clock strobe when PB_state goes 0->1
//   PB_up     output  1  one-clock strobe when PB_state goes 1->0
// BEHAVIOUR
//   - One clock domain, one synchronous active-high reset. On any clock edge with reset=1:
//     sync flops=0, counter=0, PB_state=0, PB_down=0, PB_up=0.
//     Reset wins over all other activity, including mid-count; the count is discarded.
//   - Synchroniser: two-flop chain PB -> s0 -> s1. Only s1 is used downstream.
//   - Counter: when s1 == PB_state, cnt <= 0 (idle).
//     When s1 != PB_state and cnt < STABLE_CYCLES-1, cnt <= cnt+1.
//     When s1 != PB_state and cnt == STABLE_CYCLES-1 (the STABLE_CYCLES-th differing clock):
//       PB_state <= ~PB_state and cnt <= 0;
//       on the same edge, PB_down <= ~PB_state (old value 0) or PB_up <= PB_state (old value 1).
//   - Any single clock where s1 matches PB_state restarts the count from 0.
//     Glitches shorter than STABLE_CYCLES clocks therefore never reach PB_state.
//   - Strobes are 0 on every cycle except the flip cycle. PB_down and PB_up are never both 1.
//   - Latency: a clean edge on PB appears on PB_state 2 (sync) + STABLE_CYCLES clocks later,
//     +/-1 clock for sampling alignment.
//   - Counter saturates at STABLE_CYCLES-1 by construction; no wrap-around is possible.
//   - PB held constant indefinitely: PB_state constant, strobes stay 0, no further toggles.
//   - PB_state only changes by a full debounce; no other path exists (no bypass, no preload).
// TESTING (20 ns clock, STABLE_CYCLES=100, reset asserted 5 clocks then released)
//   1. Reset: after release with PB=0 -> PB_state=0, PB_down=0, PB_up=0, cnt=0.
//   2. Bouncy press: PB 1 for 400 ns, 0 for 800 ns, 1 for 800 ns, 0 for 800 ns, then 1 for 40 us
//      -> PB_state stays 0 through the bounces; rises ~102 clocks after the final 0->1;
//         exactly one PB_down pulse; no PB_up.
//   3. Clean release: PB 1->0 and held 4 us (200 clks) -> PB_state falls ~102 clocks later;
//      exactly one PB_up pulse.
//   4. Short glitch: PB_state=1, PB drops to 0 for 800 ns (40 clks) then returns to 1
//      -> PB_state stays 1; no strobes.
//   5. Boundary: PB differs for exactly 99 synced clocks -> no flip.
//      PB differs for exactly 100 synced clocks -> flip occurs on the 100th.
//   6. Reset mid-count: PB=1 for 60 clocks, then assert reset 1 clock
//      -> cnt=0, PB_state=0; after release, a new full 100-clock window is needed before PB_state=1.

Source files
------------

// File: rtl/pb_debouncer_if.sv
// Push-button debouncer signal bundle.
// Master drives the raw button; slave returns the debounced level and strobes.
`timescale 1ns/1ps
interface pb_debouncer_if;
  logic PB;
  logic PB_state;
  logic PB_down;
  logic PB_up;

  modport master (
    output PB,
    input  PB_state,
    input  PB_down,
    input  PB_up
  );

  modport slave (
    input  PB,
    output PB_state,
    output PB_down,
    output PB_up
  );
endinterface

// File: rtl/pb_debouncer.sv
// Push-button debouncer: two-flop synchroniser, stability counter,
// registered debounced level and single-cycle press/release strobes.
`timescale 1ns/1ps
module pb_debouncer #(
  parameter int STABLE_CYCLES = 100,
  parameter int CNT_W         = 16
) (
  input  logic         clock,
  input  logic         reset,
  pb_debouncer_if.slave pb
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s0;
  logic             s1;
  logic [CNT_W-1:0] cnt;
  logic             state_q;
  logic             down_q;
  logic             up_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      s0      <= 1'b0;
      s1      <= 1'b0;
      cnt     <= '0;
      state_q <= 1'b0;
      down_q  <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      s0     <= pb.PB;
      s1     <= s0;
      down_q <= 1'b0;
      up_q   <= 1'b0;
      // any matching sample restarts the stability window
      if (s1 == state_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt     <= '0;
        state_q <= ~state_q;
        down_q  <= ~state_q;
        up_q    <= state_q;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign pb.PB_state = state_q;
  assign pb.PB_down  = down_q;
  assign pb.PB_up    = up_q;

endmodule

// File: tb/tb_pb_debouncer.sv
// Directed and randomized bench for pb_debouncer.
// Reference model: flip once the last N synced samples all differ.
`timescale 1ns/1ps
module tb_pb_debouncer;

  localparam int N = 100;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pb_debouncer_if pbi ();

  pb_debouncer #(
    .STABLE_CYCLES(N),
    .CNT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pb(pbi.slave)
  );

  always #10 clock = ~clock;

  // behavioural model
  bit m_s0, m_s1, m_st, m_dn, m_up;
  bit hist[$];

  always @(posedge clock) begin
    if (reset) begin
      m_s0 = 0; m_s1 = 0; m_st = 0;
      m_dn = 0; m_up = 0;
      hist.delete();
    end else begin
      bit all_diff;
      hist.push_back(m_s1);
      if (hist.size() > N) void'(hist.pop_front());
      all_diff = (hist.size() == N);
      foreach (hist[i])
        if (hist[i] == m_st) all_diff = 0;
      m_dn = 0;
      m_up = 0;
      if (all_diff) begin
        m_dn = !m_st;
        m_up = m_st;
        m_st = !m_st;
        hist.delete();
      end
      m_s1 = m_s0;
      m_s0 = pbi.PB;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;
  int n_dn   = 0;
  int n_up   = 0;

  task automatic chk_eq(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int got,
                         input int lo, input int hi);
    n_chk++;
    assert (got >= lo && got <= hi) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d..%0d",
             tag, got, lo, hi);
    end
  endtask

  // advance n clocks, compare against model 1ns after each edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      chk_eq("state", pbi.PB_state, m_st);
      chk_eq("down", pbi.PB_down, m_dn);
      chk_eq("up", pbi.PB_up, m_up);
      chk_eq("excl", pbi.PB_down & pbi.PB_up, 0);
      if (pbi.PB_down === 1'b1) n_dn++;
      if (pbi.PB_up === 1'b1) n_up++;
    end
  endtask

  task automatic wait_state(input logic want, input int budget,
                            output int lat);
    lat = 0;
    while (pbi.PB_state !== want && lat < budget) begin
      step(1);
      lat++;
    end
  endtask

  initial begin
    int lat, dn0, up0;
    logic seen;
    pbi.PB = 1'b0;

    // 1. reset
    step(5);
    reset = 1'b0;
    step(3);
    chk_eq("rst_state", pbi.PB_state, 0);
    chk_eq("rst_down", pbi.PB_down, 0);
    chk_eq("rst_up", pbi.PB_up, 0);

    // 2. bouncy press
    dn0 = n_dn; up0 = n_up;
    pbi.PB = 1; step(20);
    pbi.PB = 0; step(40);
    pbi.PB = 1; step(40);
    pbi.PB = 0; step(40);
    chk_eq("bounce_hold", pbi.PB_state, 0);
    pbi.PB = 1;
    wait_state(1'b1, 300, lat);
    chk_rng("press_lat", lat, N + 1, N + 3);
    step(300);
    chk_eq("press_downs", n_dn - dn0, 1);
    chk_eq("press_ups", n_up - up0, 0);

    // 4. short glitch while pressed
    dn0 = n_dn; up0 = n_up;
    pbi.PB = 0; step(40);
    pbi.PB = 1; step(200);
    chk_eq("glitch_state", pbi.PB_state, 1);
    chk_eq("glitch_strb", (n_dn - dn0) + (n_up - up0), 0);

    // 3. clean release
    up0 = n_up;
    pbi.PB = 0;
    wait_state(1'b0, 300, lat);
    chk_rng("rel_lat", lat, N + 1, N + 3);
    step(200);
    chk_eq("rel_ups", n_up - up0, 1);
    chk_eq("rel_state", pbi.PB_state, 0);

    // 5. boundary: N-1 differing clocks, then exactly N
    dn0 = n_dn;
    pbi.PB = 1; step(N - 1);
    pbi.PB = 0; step(150);
    chk_eq("n_minus1", n_dn - dn0, 0);
    chk_eq("n_minus1_st", pbi.PB_state, 0);
    pbi.PB = 1; step(N);
    pbi.PB = 0;
    seen = 1'b0;
    repeat (5) begin
      step(1);
      if (pbi.PB_state === 1'b1) seen = 1'b1;
    end
    chk_eq("exact_n", n_dn - dn0, 1);
    chk_eq("exact_n_st", seen, 1);
    wait_state(1'b0, 300, lat);
    chk_rng("bnd_rel_lat", lat, N - 5, N + 3);
    step(20);

    // 6. reset mid-count
    pbi.PB = 1; step(60);
    reset = 1'b1; step(1);
    chk_eq("midrst_st", pbi.PB_state, 0);
    reset = 1'b0;
    step(60);
    chk_eq("midrst_hold", pbi.PB_state, 0);
    wait_state(1'b1, 300, lat);
    chk_rng("midrst_lat", lat + 60, N + 1, N + 3);
    step(10);

    // 7. random segments against the model
    repeat (300) begin
      pbi.PB = 1'($urandom_range(0, 1));
      step(int'($urandom_range(1, 150)));
    end
    pbi.PB = ~pbi.PB_state;
    step(N + 10);
    chk_eq("rand_final", pbi.PB_state, m_st);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
